vga_sig_gen: RTL and testbench

VGA_SIG_GEN -- requirements
Module: vga_sig_gen

---
 rtl/vga_sig_gen_pkg.sv | 32 +++
 rtl/vga_sig_gen_generic_counter.sv | 20 ++
 rtl/vga_sig_gen.sv | 69 ++++++
 tb/tb_vga_sig_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sig_gen_pkg.sv
// Shared VGA 640x480@60 timing, frame-buffer window geometry and colour format.
package vga_sig_gen_pkg;

  localparam int CNT_W    = 10;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 8;   // RGB 3-3-2

  typedef logic [CNT_W-1:0] cnt_t;

  // Line: sync 0-95, back porch to 143, visible 144-783, front porch to 799
  localparam cnt_t H_SYNC_END  = 10'd95;
  localparam cnt_t H_VIS_START = 10'd144;
  localparam cnt_t H_VIS_END   = 10'd783;
  localparam cnt_t H_MAX       = 10'd799;

  // Frame: sync 0-1, back porch to 34, visible 35-514, front porch to 524
  localparam cnt_t V_SYNC_END  = 10'd1;
  localparam cnt_t V_VIS_START = 10'd35;
  localparam cnt_t V_VIS_END   = 10'd514;
  localparam cnt_t V_MAX       = 10'd524;

  // 256x128 buffer shown 2x2 scaled, centred in the visible area
  localparam cnt_t WIN_X_MIN = 10'd64;
  localparam cnt_t WIN_X_MAX = 10'd575;
  localparam cnt_t WIN_Y_MIN = 10'd112;
  localparam cnt_t WIN_Y_MAX = 10'd367;

  function automatic logic in_span(cnt_t v, cnt_t lo, cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sig_gen_generic_counter.sv
// Wrapping 0..MAX counter; TRIG_OUT flags the enabled cycle that wraps, for chaining.
module generic_counter #(
  parameter int WIDTH = 10,
  parameter int MAX   = 799
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             ENABLE,
  output logic [WIDTH-1:0] COUNT,
  output logic             TRIG_OUT
);

  assign TRIG_OUT = ENABLE && (COUNT == WIDTH'(MAX));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)     COUNT <= '0;
    else if (ENABLE) COUNT <= TRIG_OUT ? '0 : COUNT + 1'b1;
  end

endmodule

// File: rtl/vga_sig_gen.sv
// VGA sync/colour generator scanning a 256x128 1-bpp frame buffer at 2x scale.
module vga_sig_gen
  import vga_sig_gen_pkg::*;
#(
  parameter logic [COLOUR_W-1:0] FG_DEFAULT = 8'hFF,
  parameter logic [COLOUR_W-1:0] BG_DEFAULT = 8'h03
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                FG_SEL,
  input  logic                BG_SEL,
  input  logic [COLOUR_W-1:0] FG_COLOUR,
  input  logic [COLOUR_W-1:0] BG_COLOUR,
  output logic [ADDR_W-1:0]   B_ADDR,
  input  logic                B_DATA,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic [COLOUR_W-1:0] VGA_COLOUR,
  output logic                FRAME_START
);

  logic pix_en;
  cnt_t hcount, vcount, x, y;
  logic h_wrap, v_wrap, visible, in_win;
  logic [COLOUR_W-1:0] fg, bg;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) pix_en <= 1'b0;
    else         pix_en <= ~pix_en;
  end

  generic_counter #(.WIDTH(CNT_W), .MAX(int'(H_MAX))) u_hcnt (
    .CLK(CLK), .RESETN(RESETN), .ENABLE(pix_en), .COUNT(hcount), .TRIG_OUT(h_wrap)
  );

  generic_counter #(.WIDTH(CNT_W), .MAX(int'(V_MAX))) u_vcnt (
    .CLK(CLK), .RESETN(RESETN), .ENABLE(h_wrap), .COUNT(vcount), .TRIG_OUT(v_wrap)
  );

  // Vertical wrap only fires on a pixel tick at the last pixel of the last line
  assign FRAME_START = v_wrap;

  // x/y wrap to large values during blanking; visible gates them first
  assign x       = hcount - H_VIS_START;
  assign y       = vcount - V_VIS_START;
  assign visible = in_span(hcount, H_VIS_START, H_VIS_END) && in_span(vcount, V_VIS_START, V_VIS_END);
  assign in_win  = visible && in_span(x, WIN_X_MIN, WIN_X_MAX) && in_span(y, WIN_Y_MIN, WIN_Y_MAX);

  assign B_ADDR = in_win ? {7'((y - WIN_Y_MIN) >> 1), 8'((x - WIN_X_MIN) >> 1)} : '0;

  assign fg = FG_SEL ? FG_COLOUR : FG_DEFAULT;
  assign bg = BG_SEL ? BG_COLOUR : BG_DEFAULT;

  // B_DATA arrives one CLK after B_ADDR, so the pixel-tick edge sees the matching bit
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      VGA_COLOUR <= '0;
    end else if (pix_en) begin
      VGA_HS <= hcount > H_SYNC_END;
      VGA_VS <= vcount > V_SYNC_END;
      if (!visible)              VGA_COLOUR <= '0;
      else if (in_win && B_DATA) VGA_COLOUR <= fg;
      else                       VGA_COLOUR <= bg;
    end
  end

endmodule

// File: tb/tb_vga_sig_gen.sv
// Scoreboard bench: stimulus queues expected values keyed by CLK count since reset release.
module tb_vga_sig_gen;

  logic        CLK, RESETN, FG_SEL, BG_SEL, B_DATA, VGA_HS, VGA_VS, FRAME_START;
  logic [7:0]  FG_COLOUR, BG_COLOUR, VGA_COLOUR;
  logic [14:0] B_ADDR;
  logic [9:0]  vf;
  bit          mem [0:32767];

  typedef struct {
    string       name;
    int          cyc;
    int          kind;   // 0 {hs,vs,colour}, 1 B_ADDR, 2 FRAME_START, 3 frame-start count
    logic [16:0] val;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   cyc, fs_cnt;

  vga_sig_gen dut (
    .CLK(CLK), .RESETN(RESETN), .FG_SEL(FG_SEL), .BG_SEL(BG_SEL),
    .FG_COLOUR(FG_COLOUR), .BG_COLOUR(BG_COLOUR), .B_ADDR(B_ADDR), .B_DATA(B_DATA),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_COLOUR(VGA_COLOUR), .FRAME_START(FRAME_START)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // Frame-buffer model: synchronous read, data one CLK after address
  always @(posedge CLK) B_DATA <= mem[B_ADDR];

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cyc    <= 0;
      fs_cnt <= 0;
    end else begin
      cyc    <= cyc + 1;
      fs_cnt <= fs_cnt + int'(FRAME_START);
    end
  end

  function automatic void check(string name, logic [16:0] act, logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge CLK) begin
    if (RESETN) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc < cyc) begin
          check({q[i].name, "_missed"}, 17'(cyc), 17'(q[i].cyc));
          q.delete(i);
        end else if (q[i].cyc == cyc) begin
          case (q[i].kind)
            0:       check(q[i].name, {7'b0, VGA_HS, VGA_VS, VGA_COLOUR}, q[i].val);
            1:       check(q[i].name, {2'b0, B_ADDR}, q[i].val);
            2:       check(q[i].name, {16'b0, FRAME_START}, q[i].val);
            default: check(q[i].name, 17'(fs_cnt), q[i].val);
          endcase
          q.delete(i);
        end
      end
    end
  end

  task automatic push(string name, int c, int kind, logic [16:0] val);
    exp_t e;
    e.name = name; e.cyc = c; e.kind = kind; e.val = val;
    q.push_back(e);
  endtask

  // Pixel (h, line j after release) is output at the pixel-tick edge 2 CLK after the counter reaches it
  task automatic pix(string name, int j, int h, logic hs, logic vs, logic [7:0] col);
    push(name, 1600 * j + 2 * h + 2, 0, {7'b0, hs, vs, col});
  endtask

  task automatic addr(string name, int j, int h, logic [14:0] a);
    push(name, 1600 * j + 2 * h, 1, {2'b0, a});
  endtask

  task automatic wait_cyc(int c);
    for (int n = 0; n < 40000 && cyc < c; n++) @(negedge CLK);
    check("wait_cyc_timeout", 17'(cyc >= c), 17'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 20000 && q.size() > 0; n++) @(negedge CLK);
    check("drain", 17'(q.size()), 17'd0);
    q.delete();
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    RESETN = 1'b0;
    FG_SEL = 1'b0; BG_SEL = 1'b0; FG_COLOUR = 8'h00; BG_COLOUR = 8'h00;
    repeat (2) @(negedge CLK);
  endtask

  task automatic release_dut();
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  // Jump the line counter early in line 0 so later rows are reachable quickly
  task automatic force_v(logic [9:0] v);
    vf = v;
    wait_cyc(10);
    force dut.u_vcnt.COUNT = vf;
    #1;
    release dut.u_vcnt.COUNT;
  endtask

  initial begin
    RESETN = 1'b0; FG_SEL = 1'b0; BG_SEL = 1'b0; FG_COLOUR = 8'h00; BG_COLOUR = 8'h00; vf = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_hs", {16'b0, VGA_HS}, 17'd1);
    check("rst_vs", {16'b0, VGA_VS}, 17'd1);
    check("rst_col", {9'b0, VGA_COLOUR}, 17'h00);
    check("rst_fs", {16'b0, FRAME_START}, 17'd0);
    check("rst_addr", {2'b0, B_ADDR}, 17'd0);

    // Sync timing from line 0: HS low 96 pixels (192 CLK), VS low two lines (3200 CLK)
    pix("a_first", 0, 0, 0, 0, 8'h00);
    pix("a_hs_last_low", 0, 95, 0, 0, 8'h00);
    pix("a_hs_rise", 0, 96, 1, 0, 8'h00);
    pix("a_line_end", 0, 799, 1, 0, 8'h00);
    pix("a_l1_start", 1, 0, 0, 0, 8'h00);
    pix("a_vs_last_low", 1, 799, 1, 0, 8'h00);
    pix("a_vs_rise", 2, 0, 0, 1, 8'h00);
    pix("a_vblank", 2, 500, 1, 1, 8'h00);
    push("a_fs_none", 1599, 2, 17'd0);
    push("a_fscnt", 3300, 3, 17'd0);
    release_dut();
    drain();

    // Window top-left corner, address mapping and mid-line colour switch
    reset_dut();
    mem[0] = 1'b1;
    mem[15'h101] = 1'b1;
    for (int xx = 10; xx <= 20; xx++) mem[15'h200 + xx] = 1'b1;
    pix("b_above", 0, 208, 1, 1, 8'h03);
    addr("b_above_a", 0, 300, 15'h0000);
    pix("b_hbp", 1, 143, 1, 1, 8'h00);
    pix("b_x0", 1, 144, 1, 1, 8'h03);
    pix("b_x63", 1, 207, 1, 1, 8'h03);
    pix("b_x64", 1, 208, 1, 1, 8'hFF);
    pix("b_x65", 1, 209, 1, 1, 8'hFF);
    pix("b_x66", 1, 210, 1, 1, 8'h03);
    pix("b_x639", 1, 783, 1, 1, 8'h03);
    pix("b_hfp", 1, 784, 1, 1, 8'h00);
    addr("b_a_x63", 1, 207, 15'h0000);
    addr("b_a_x66", 1, 210, 15'h0001);
    addr("b_a_x575", 1, 719, 15'h00FF);
    addr("b_a_x576", 1, 720, 15'h0000);
    pix("b_y113_x64", 2, 208, 1, 1, 8'hFF);
    pix("b_y113_x65", 2, 209, 1, 1, 8'hFF);
    pix("b_y113_x66", 2, 210, 1, 1, 8'h03);
    addr("b_a_y113", 2, 210, 15'h0001);
    pix("b_y114_x64", 3, 208, 1, 1, 8'h03);
    pix("b_y114_x66", 3, 210, 1, 1, 8'hFF);
    pix("b_y114_x67", 3, 211, 1, 1, 8'hFF);
    pix("b_y114_x68", 3, 212, 1, 1, 8'h03);
    addr("b_a_y114", 3, 210, 15'h0101);
    pix("b_y115_x67", 4, 211, 1, 1, 8'hFF);
    pix("c_pre_bg", 5, 227, 1, 1, 8'h03);
    pix("c_pre_fg", 5, 234, 1, 1, 8'hFF);
    pix("c_new_fg", 5, 235, 1, 1, 8'hE0);
    pix("c_new_fg_end", 5, 249, 1, 1, 8'hE0);
    pix("c_new_bg", 5, 250, 1, 1, 8'h1C);
    pix("c_hblank", 6, 143, 1, 1, 8'h00);
    pix("c_next_bg", 6, 226, 1, 1, 8'h1C);
    pix("c_next_fg", 6, 228, 1, 1, 8'hE0);
    release_dut();
    force_v(10'd146);
    wait_cyc(1600 * 5 + 2 * 235 + 1);
    FG_SEL = 1'b1; FG_COLOUR = 8'hE0; BG_SEL = 1'b1; BG_COLOUR = 8'h1C;
    drain();

    // Window bottom-right corner and right/bottom edges
    reset_dut();
    mem[15'h7FFF] = 1'b1;
    addr("d_a_x64", 0, 208, 15'h7F00);
    pix("d_x64", 0, 208, 1, 1, 8'h03);
    addr("d_a_max", 0, 719, 15'h7FFF);
    pix("d_max", 0, 719, 1, 1, 8'hFF);
    addr("d_a_x576", 0, 720, 15'h0000);
    pix("d_x576", 0, 720, 1, 1, 8'h03);
    pix("d_hfp", 0, 784, 1, 1, 8'h00);
    addr("d_a_y368", 1, 208, 15'h0000);
    pix("d_y368", 1, 208, 1, 1, 8'h03);
    release_dut();
    force_v(10'd402);
    drain();

    // Reset asserted mid-frame at HCOUNT=400, VCOUNT=200
    reset_dut();
    pix("e_pre", 0, 399, 1, 1, 8'h03);
    addr("e_pre_a", 0, 400, 15'h1A60);
    release_dut();
    force_v(10'd200);
    wait_cyc(801);
    RESETN = 1'b0;
    #1;
    check("e_rst_hs", {16'b0, VGA_HS}, 17'd1);
    check("e_rst_vs", {16'b0, VGA_VS}, 17'd1);
    check("e_rst_col", {9'b0, VGA_COLOUR}, 17'h00);
    check("e_rst_fs", {16'b0, FRAME_START}, 17'd0);
    check("e_rst_addr", {2'b0, B_ADDR}, 17'd0);
    check("e_rst_queue", 17'(q.size()), 17'd0);
    repeat (3) @(negedge CLK);
    pix("e_restart", 0, 0, 0, 0, 8'h00);
    pix("e_line1", 1, 0, 0, 0, 8'h00);
    pix("e_line2", 2, 0, 0, 1, 8'h00);
    push("e_fscnt", 3300, 3, 17'd0);
    release_dut();
    drain();

    // Frame wrap: FRAME_START high only on the pixel tick that wraps both counters
    reset_dut();
    push("f_pre", 1598, 2, 17'd0);
    push("f_pulse", 1599, 2, 17'd1);
    push("f_post", 1600, 2, 17'd0);
    push("f_cnt", 1700, 3, 17'd1);
    pix("f_v524", 0, 799, 1, 1, 8'h00);
    pix("f_wrap", 1, 0, 0, 0, 8'h00);
    release_dut();
    force_v(10'd524);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge CLK);
    failures++;
    $display("FAIL watchdog: got cycle budget exhausted expected bench completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
